// File: rtl/sprite_pkg.sv
// Shared constants for the sprite pixel path: colour format, background and
// transparent colours, element ids and the default ROM read latency.
package sprite_pkg;

    localparam int ELEMENT_W    = 5;
    localparam int ADDR_W       = 10;
    localparam int COLOR_W      = 9;
    localparam int MEM_LATENCY  = 2;
    localparam int NUM_ELEMENTS = 5;

    localparam logic [COLOR_W-1:0] BG_COLOR          = 9'h000;
    localparam logic [COLOR_W-1:0] TRANSPARENT_COLOR = 9'h1C7;

    // Element 0 means "no sprite" and is never a legal ROM read.
    typedef enum logic [ELEMENT_W-1:0] {
        ELEM_NONE    = 5'd0,
        ELEM_FRUIT   = 5'd1,
        ELEM_HEART   = 5'd2,
        ELEM_BARRIER = 5'd5
    } element_e;

endpackage

// File: rtl/sprite_delay_line.sv
// Reset-clearable shift register. Carries per-pixel side information so it
// lines up with ROM data that returns a fixed number of cycles later.
module sprite_delay_line #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // Next value of every stage: new sample enters stage 0, others shift by one.
    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers; reset empties the whole pipe so no stale pixel survives.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/sprite_pixel_fetch.sv
// Sprite pixel fetch: turns {ready, element, address} per pixel into a ROM read,
// waits the fixed ROM latency and drives the final RGB for the DAC.
// Non-sprite active pixels get BG_COLOR, blanking gets 0. Illegal requests
// (element 0 or above NUM_ELEMENTS) are treated as misses and set a sticky flag.
// Optional feature macro: SPRITE_TRANSPARENCY_EN -- when defined, ROM data equal
// to TRANSPARENT_COLOR on a hit is replaced by BG_COLOR.
module sprite_pixel_fetch #(
    parameter int ELEMENT      = sprite_pkg::ELEMENT_W,
    parameter int ADDR_W       = sprite_pkg::ADDR_W,
    parameter int COLOR_W      = sprite_pkg::COLOR_W,
    parameter int MEM_LATENCY  = sprite_pkg::MEM_LATENCY,
    parameter int NUM_ELEMENTS = sprite_pkg::NUM_ELEMENTS,
    parameter logic [COLOR_W-1:0] BG_COLOR = sprite_pkg::BG_COLOR
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      active,
    input  logic                      ready,
    input  logic [ELEMENT-1:0]        element,
    input  logic [ADDR_W-1:0]         address,
    output logic                      mem_rd,
    output logic [ELEMENT+ADDR_W-1:0] mem_addr,
    input  logic [COLOR_W-1:0]        mem_data,
    output logic [COLOR_W-1:0]        rgb,
    output logic                      rgb_valid,
    output logic                      err_illegal
);

    import sprite_pkg::*;

    localparam logic [ELEMENT-1:0] MAX_ELEM = ELEMENT'(NUM_ELEMENTS);

`ifdef SPRITE_TRANSPARENCY_EN
    localparam logic [COLOR_W-1:0] TRANSP_COLOR = COLOR_W'(TRANSPARENT_COLOR);
`endif

    // Stage S0 decode: a hit is a legal sprite request during active video.
    logic legal;
    logic req;
    logic hit;

    assign legal = (element != '0) && (element <= MAX_ELEM);
    assign req   = ready & active;
    assign hit   = req & legal;

    logic                      mem_rd_q,   mem_rd_d;
    logic [ELEMENT+ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic                      err_q,      err_d;
    logic [COLOR_W-1:0]        rgb_q,      rgb_d;
    logic                      rgb_valid_q, rgb_valid_d;

    // Aligned copies of hit/active, arriving together with the ROM data.
    logic hit_dl;
    logic active_dl;

    sprite_delay_line #(
        .WIDTH (2),
        .DEPTH (MEM_LATENCY)
    ) u_align (
        .clk   (clk),
        .reset (reset),
        .din   ({hit, active}),
        .dout  ({hit_dl, active_dl})
    );

    // S0 next state: issue the read on a hit, hold the address otherwise,
    // and latch any illegal request into the sticky error.
    always_comb begin
        mem_rd_d   = hit;
        mem_addr_d = mem_addr_q;
        if (hit) begin
            mem_addr_d = {element, address};
        end
        err_d = err_q | (req & ~legal);
    end

    // Output mux: blank, ROM colour on a hit, or background on a miss.
    always_comb begin
        rgb_d       = '0;
        rgb_valid_d = 1'b0;
        if (active_dl) begin
            rgb_valid_d = 1'b1;
            if (hit_dl) begin
`ifdef SPRITE_TRANSPARENCY_EN
                rgb_d = (mem_data == TRANSP_COLOR) ? BG_COLOR : mem_data;
`else
                rgb_d = mem_data;
`endif
            end else begin
                rgb_d = BG_COLOR;
            end
        end
    end

    // All block state; synchronous active-low reset flushes everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            err_q       <= 1'b0;
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
        end else begin
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            err_q       <= err_d;
            rgb_q       <= rgb_d;
            rgb_valid_q <= rgb_valid_d;
        end
    end

    assign mem_rd      = mem_rd_q;
    assign mem_addr    = mem_addr_q;
    assign err_illegal = err_q;
    assign rgb         = rgb_q;
    assign rgb_valid   = rgb_valid_q;

endmodule
